// File: rtl/ka_5bit_seq_ctrl_if.sv
// Operand/result handshake bundle for ka_5bit_seq_ctrl.
//   in_valid/in_ready/a/b : operand channel (producer -> controller)
//   out_valid/out_ready/y : product channel (controller -> consumer)
// master: the environment that supplies operands and consumes products.
// slave : the multiplier controller.
interface ka_5bit_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] y;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/ka_5bit_seq_ctrl.sv
// Iterative carry-less 5x5-bit Karatsuba multiplier controller.
// One 3x3 carry-less core is time-shared over three phases:
//   P0 = lo*lo, P1 = hi*hi, P2 = (lo^hi)*(lo^hi)
// with lo = x[2:0], hi = {1'b0, x[4:3]}. The 9-bit product is
//   y = p0 ^ ((p0 ^ p1 ^ p2) << 3) ^ (p1 << 6)
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   acc_clr     : clear accumulator (only with KA_SEQ_ACC_EN)
//   bus         : slave side of ka_5bit_seq_ctrl_if (operands in, product out)
//   busy        : high in any phase state P0/P1/P2
//   op_count    : number of output handshakes since reset (wraps)
// Build option: define KA_SEQ_ACC_EN to add a 9-bit GF(2) accumulator, making
// y = product ^ acc and acc <= y on every output handshake.
module ka_5bit_seq_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef KA_SEQ_ACC_EN
  input  logic              acc_clr,
`endif
  ka_5bit_seq_ctrl_if.slave bus,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StDone} state_e;

  state_e          state_q, state_d;
  logic [4:0]      a_q, b_q;
  logic [4:0]      p0_q, p1_q;
  logic [8:0]      y_q, y_d;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]      core_a, core_b;
  logic [4:0]      core_p;
  logic [8:0]      prod, mid_sh, p1_sh;
  logic            in_ready, out_valid, accept, out_hs;

  // 3x3 carry-less core shared by all three phases.
  function automatic logic [4:0] clmul3(input logic [2:0] x, input logic [2:0] z);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      if (z[i]) r = r ^ ({2'b00, x} << i);
    end
    return r;
  endfunction

  // Core operand select depends on the registered state only, so the core
  // inputs are stable for the whole phase.
  always_comb begin
    core_a = '0;
    core_b = '0;
    case (state_q)
      StP0: begin
        core_a = a_q[2:0];
        core_b = b_q[2:0];
      end
      StP1: begin
        core_a = {1'b0, a_q[4:3]};
        core_b = {1'b0, b_q[4:3]};
      end
      StP2: begin
        core_a = a_q[2:0] ^ {1'b0, a_q[4:3]};
        core_b = b_q[2:0] ^ {1'b0, b_q[4:3]};
      end
      default: ;
    endcase
  end

  assign core_p = clmul3(core_a, core_b);

  // Karatsuba recombination; p1 has degree <= 2, so nothing is lost above bit 8.
  assign mid_sh = {4'b0000, p0_q ^ p1_q ^ core_p} << 3;
  assign p1_sh  = {4'b0000, p1_q} << 6;
  assign prod   = {4'b0000, p0_q} ^ mid_sh ^ p1_sh;

`ifdef KA_SEQ_ACC_EN
  logic [8:0] acc_q;
  assign y_d = prod ^ acc_q;
`else
  assign y_d = prod;
`endif

  always_comb begin
    in_ready  = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
    out_valid = (state_q == StDone);
    busy      = (state_q == StP0) | (state_q == StP1) | (state_q == StP2);
    accept    = bus.in_valid & in_ready;
    out_hs    = out_valid & bus.out_ready;

    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StP0;
      StP0:    state_d = StP1;
      StP1:    state_d = StP2;
      StP2:    state_d = StDone;
      // A handshake and a new accept may share the same edge.
      StDone:  if (bus.out_ready) state_d = bus.in_valid ? StP0 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
      if (state_q == StP0) p0_q <= core_p;
      if (state_q == StP1) p1_q <= core_p;
      if (state_q == StP2) y_q  <= y_d;
      if (out_hs)          cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef KA_SEQ_ACC_EN
  // Clear wins over the handshake update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (out_hs) begin
      acc_q <= y_q;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = y_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_ka_5bit_seq_ctrl.sv
module tb_ka_5bit_seq_ctrl;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] op_count;
`ifdef KA_SEQ_ACC_EN
  logic             acc_clr;
`endif

  ka_5bit_seq_ctrl_if bus();

  ka_5bit_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef KA_SEQ_ACC_EN
    .acc_clr  (acc_clr),
`endif
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [8:0]  m_acc;  // accumulator model (stays 0 without the option)
  int unsigned m_cnt;  // expected handshake count

  // Reference: plain shift-and-xor polynomial multiply over GF(2).
  function automatic logic [8:0] clmul5(input logic [4:0] x, input logic [4:0] z);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (z[i]) r = r ^ ({4'b0000, x} << i);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_y"}, bus.y, 0);
    check({tag, "_op_count"}, op_count, 0);
  endtask

  // One complete operation with out_ready held high; prod is the bare product.
  task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic [8:0] prod);
    int         n;
    logic [8:0] exp_y;
    bus.a = a;
    bus.b = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_in_ready"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    bus.a = 5'($urandom);
    bus.b = 5'($urandom);
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check({tag, "_out_valid_timeout"}, bus.out_valid, 1);
    exp_y = prod ^ m_acc;
    check({tag, "_y"}, bus.y, exp_y);
    step();
`ifdef KA_SEQ_ACC_EN
    m_acc = exp_y;
`endif
    m_cnt++;
    check({tag, "_op_count"}, op_count, m_cnt);
  endtask

  initial begin
    logic [4:0] ra, rb;
    logic [8:0] exp_y, e_y;
    logic [8:0] q[$];
    int         n, acc_n, out_n, cyc, last, hits;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
`ifdef KA_SEQ_ACC_EN
    acc_clr       = 1'b0;
`endif
    m_acc = '0;
    m_cnt = 0;
    #1;
    check_reset("rst");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    check_reset("post_rst");

    // Directed and corner products.
    run_op("single", 5'b10101, 5'b00111, 9'b001101011);
    run_op("ones",   5'b11111, 5'b11111, 9'b101010101);
    run_op("top",    5'b10000, 5'b10000, 9'h100);
    run_op("zero",   5'b00000, 5'b11111, 9'h000);
    run_op("small",  5'b00010, 5'b00011, 9'b000000110);

    // Random single operations.
    for (int i = 0; i < 10; i++) begin
      ra = 5'($urandom);
      rb = 5'($urandom);
      run_op("rand", ra, rb, clmul5(ra, rb));
    end

    // Backpressure: hold in DONE for 10 cycles with stray in_valid pulses.
    ra = 5'($urandom);
    rb = 5'($urandom);
    bus.a = ra;
    bus.b = rb;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    exp_y = clmul5(ra, rb) ^ m_acc;
    check("bp_y", bus.y, exp_y);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a = 5'($urandom);
      bus.b = 5'($urandom);
      check("bp_in_ready", bus.in_ready, 0);
      step();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_y_hold", bus.y, exp_y);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
`ifdef KA_SEQ_ACC_EN
    m_acc = exp_y;
`endif
    m_cnt++;
    check("bp_release_out_valid", bus.out_valid, 0);
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_op_count", op_count, m_cnt);

    // Back-to-back traffic: in_valid held high for 8 accepts.
    acc_n = 0;
    out_n = 0;
    cyc   = 0;
    last  = -1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    while (out_n < 8 && cyc < 200) begin
      if (bus.out_valid) begin
        if (q.size() > 0) begin
          e_y = q.pop_front();
          check("b2b_y", bus.y, e_y);
        end else begin
          check("b2b_unexpected_out", bus.out_valid, 0);
        end
        if (last >= 0) check("b2b_gap", cyc - last, 4);
        last = cyc;
        out_n++;
        m_cnt++;
      end
      if (acc_n < 8) begin
        ra = 5'($urandom);
        rb = 5'($urandom);
        bus.a = ra;
        bus.b = rb;
        if (bus.in_ready) begin
          e_y = clmul5(ra, rb) ^ m_acc;
`ifdef KA_SEQ_ACC_EN
          m_acc = e_y;
`endif
          q.push_back(e_y);
          acc_n++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("b2b_outputs", out_n, 8);
    check("b2b_op_count", op_count, m_cnt);

    // Reset while in P1: everything returns to reset values, nothing emerges.
    bus.a = 5'($urandom);
    bus.b = 5'($urandom);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check("p1_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    m_acc = '0;
    m_cnt = 0;
    #2;
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) hits++;
    end
    check("mid_rst_no_output", hits, 0);
    check("mid_rst_op_count", op_count, 0);

`ifdef KA_SEQ_ACC_EN
    // Multiply-accumulate of 1*1 three times, then clear.
    run_op("mac1", 5'b00001, 5'b00001, 9'h001);
    check("mac1_const", bus.y, 9'h001);
    run_op("mac2", 5'b00001, 5'b00001, 9'h001);
    check("mac2_const", bus.y, 9'h000);
    run_op("mac3", 5'b00001, 5'b00001, 9'h001);
    check("mac3_const", bus.y, 9'h001);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    m_acc = '0;
    run_op("mac_clr", 5'b00001, 5'b00001, 9'h001);
    check("mac_clr_const", bus.y, 9'h001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
